// File: rtl/seq_restoring_divider_pkg.sv
// ============================================================================
// Module  : seq_restoring_divider_pkg
// Purpose : State encodings and constants shared by the restoring divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_restoring_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Wide enough for any supported N; the top slices off its own width.
  localparam int                    DBZ_MAX_W    = 64;
  localparam logic [DBZ_MAX_W-1:0]  DBZ_QUOTIENT = '1;

endpackage

`default_nettype wire

// File: rtl/seq_restoring_divider_ks_subtractor.sv
// ============================================================================
// Module  : ks_subtractor
// Purpose : W-bit Kogge-Stone subtractor computing a - b as a + ~b + 1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ks_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int LV = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]          w_bn;
  logic [W-1:0]          w_p;
  logic [LV:0][W-1:0]    w_g;
  logic [LV-1:0][W-1:0]  w_pp;

  assign w_bn = ~b;
  assign w_p  = a ^ w_bn;

  // Carry-in of 1 is folded into bit 0, so bit 0 never propagates.
  assign w_g[0][0]  = (a[0] & w_bn[0]) | w_p[0];
  assign w_pp[0][0] = 1'b0;

  generate
    for (genvar i = 1; i < W; i++) begin : g_init
      assign w_g[0][i]  = a[i] & w_bn[i];
      assign w_pp[0][i] = w_p[i];
    end

    for (genvar k = 0; k < LV; k++) begin : g_level
      localparam int D = 1 << k;
      for (genvar i = 0; i < W; i++) begin : g_bit
        if (i >= D) begin : g_merge
          assign w_g[k+1][i] = w_g[k][i] | (w_pp[k][i] & w_g[k][i-D]);
          if (k + 1 < LV) begin : g_prop
            assign w_pp[k+1][i] = w_pp[k][i] & w_pp[k][i-D];
          end
        end else begin : g_pass
          // Prefix already reaches bit 0 here, so the group propagate is 0.
          assign w_g[k+1][i] = w_g[k][i] | (w_pp[k][i] & 1'b0);
          if (k + 1 < LV) begin : g_prop
            assign w_pp[k+1][i] = w_pp[k][i];
          end
        end
      end
    end

    assign diff[0] = ~w_p[0];
    for (genvar i = 1; i < W; i++) begin : g_sum
      assign diff[i] = w_p[i] ^ w_g[LV][i-1];
    end
  endgenerate

  assign borrow_out = ~w_g[LV][W-1];

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module  : seq_restoring_divider
// Purpose : Iterative unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  logic [1:0]    r_state;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;
  logic [N-1:0]  r_d;
  logic [CW-1:0] r_count;
  logic          r_dbz;

  logic [N:0]    w_t;
  logic [N:0]    w_diff;
  logic          w_borrow;
  logic          w_unused_diff_msb;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign w_t = {r_r, r_q[N-1]};

  ks_subtractor #(
    .W (N + 1)
  ) u_sub (
    .a          (w_t),
    .b          ({1'b0, r_d}),
    .diff       (w_diff),
    .borrow_out (w_borrow)
  );

  assign w_unused_diff_msb = w_diff[N];

  assign in_ready    = rst_n & (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_count <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_d <= divisor;
            if (divisor == '0) begin
              r_q     <= DBZ_QUOTIENT[N-1:0];
              r_r     <= dividend;
              r_dbz   <= 1'b1;
              r_count <= '0;
              r_state <= ST_DONE;
            end else begin
              r_q     <= dividend;
              r_r     <= '0;
              r_dbz   <= 1'b0;
              r_count <= CW'(N);
              r_state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          r_q     <= {r_q[N-2:0], ~w_borrow};
          r_r     <= w_borrow ? w_t[N-1:0] : w_diff[N-1:0];
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module  : tb_seq_restoring_divider
// Purpose : Directed checks of the N=8 divider plus an exhaustive N=4 sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] dividend4 = '0;
  logic [3:0] divisor4 = '0;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [3:0] quotient4;
  logic [3:0] remainder4;
  logic       div_by_zero4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.N(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_restoring_divider #(.N(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .dividend    (dividend4),
    .divisor     (divisor4),
    .out_valid   (out_valid4),
    .out_ready   (out_ready4),
    .quotient    (quotient4),
    .remainder   (remainder4),
    .div_by_zero (div_by_zero4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands once in_ready is seen; returns just after the acceptance edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check_eq("start_timeout", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  int lat;

  initial begin
    // Reset state
    #12;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_quot", {24'd0, quotient}, 32'd0);
    check_eq("rst_rem", {24'd0, remainder}, 32'd0);
    check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // 100 / 7
    out_ready = 1'b1;
    start8(8'd100, 8'd7);
    wait_valid8(lat);
    check_eq("t1_lat", lat, 32'd8);
    check_eq("t1_quot", {24'd0, quotient}, 32'd14);
    check_eq("t1_rem", {24'd0, remainder}, 32'd2);
    check_eq("t1_dbz", {31'd0, div_by_zero}, 32'd0);
    check_eq("t1_busy", {31'd0, in_ready}, 32'd0);
    step();
    check_eq("t1_ov_drop", {31'd0, out_valid}, 32'd0);
    check_eq("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // 255 / 1 then 5 / 9 back to back
    start8(8'd255, 8'd1);
    wait_valid8(lat);
    check_eq("t2a_lat", lat, 32'd8);
    check_eq("t2a_quot", {24'd0, quotient}, 32'd255);
    check_eq("t2a_rem", {24'd0, remainder}, 32'd0);
    check_eq("t2a_no_ready", {31'd0, in_ready}, 32'd0);
    start8(8'd5, 8'd9);
    wait_valid8(lat);
    check_eq("t2b_lat", lat, 32'd8);
    check_eq("t2b_quot", {24'd0, quotient}, 32'd0);
    check_eq("t2b_rem", {24'd0, remainder}, 32'd5);
    step();

    // 200 / 0
    start8(8'd200, 8'd0);
    wait_valid8(lat);
    check_eq("t3_lat", lat, 32'd0);
    check_eq("t3_quot", {24'd0, quotient}, 32'd255);
    check_eq("t3_rem", {24'd0, remainder}, 32'd200);
    check_eq("t3_dbz", {31'd0, div_by_zero}, 32'd1);
    step();
    check_eq("t3_ov_drop", {31'd0, out_valid}, 32'd0);

    // 250 / 16 with consumer back-pressure
    out_ready = 1'b0;
    start8(8'd250, 8'd16);
    wait_valid8(lat);
    check_eq("t4_lat", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      dividend = 8'd3;
      divisor  = 8'd1;
      in_valid = 1'b1;
      step();
      check_eq("t4_hold_ov", {31'd0, out_valid}, 32'd1);
      check_eq("t4_hold_quot", {24'd0, quotient}, 32'd15);
      check_eq("t4_hold_rem", {24'd0, remainder}, 32'd10);
      check_eq("t4_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("t4_ov_drop", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("t4_single_hs", {31'd0, out_valid}, 32'd0);
    check_eq("t4_idle_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-run of 77 / 3
    start8(8'd77, 8'd3);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_ov", {31'd0, out_valid}, 32'd0);
    check_eq("t5_rst_quot", {24'd0, quotient}, 32'd0);
    check_eq("t5_rst_rem", {24'd0, remainder}, 32'd0);
    check_eq("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("t5_rel_ready", {31'd0, in_ready}, 32'd1);
    start8(8'd77, 8'd3);
    wait_valid8(lat);
    check_eq("t5_lat", lat, 32'd8);
    check_eq("t5_quot", {24'd0, quotient}, 32'd25);
    check_eq("t5_rem", {24'd0, remainder}, 32'd2);
    step();

    // Exhaustive 4-bit sweep against a behavioural model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int n;
        logic [3:0] eq, er;
        logic       ez;
        if (b == 0) begin
          eq = 4'hF;
          er = 4'(a);
          ez = 1'b1;
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
          ez = 1'b0;
        end
        n = 0;
        while (!in_ready4 && n < 50) begin
          step();
          n++;
        end
        if (n >= 50) check_eq("sw_start_timeout", {31'd0, in_ready4}, 32'd1);
        dividend4 = 4'(a);
        divisor4  = 4'(b);
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 50) begin
          step();
          n++;
        end
        if (n >= 50) check_eq("sw_done_timeout", {31'd0, out_valid4}, 32'd1);
        check_eq("sw_quot", {28'd0, quotient4}, {28'd0, eq});
        check_eq("sw_rem", {28'd0, remainder4}, {28'd0, er});
        check_eq("sw_dbz", {31'd0, div_by_zero4}, {31'd0, ez});
        if (b != 0) check_eq("sw_rem_lt_div", {31'd0, (remainder4 < 4'(b))}, 32'd1);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
